// File: rtl/pmem_burst_responder.sv
// Line-addressed burst memory: accepts 256-bit line requests and moves them as four 64-bit beats.
// Optional protocol checker enabled by defining PMEM_PROTO_CHECK_EN (adds protocol_err output).
module pmem_burst_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        busy
`ifdef PMEM_PROTO_CHECK_EN
  ,
  output logic        protocol_err
`endif
);

  localparam int IW  = $clog2(DEPTH);
  localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [255:0]   mem_q [DEPTH];
  logic [1:0]     state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [1:0]     beat_q, beat_d;
  logic           op_wr_q, op_wr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [63:0]    rdata_q, rdata_d;
  logic           resp_q, resp_d;
  logic           busy_q, busy_d;

  logic [255:0]   line_s;
  logic           accept_s;
  logic           rd_load_s;
  logic [1:0]     rd_beat_s;

  assign line_s = mem_q[idx_q];

  // Next-state logic; DONE behaves like IDLE for acceptance so a held request re-arms at its last edge.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    beat_d    = beat_q;
    op_wr_d   = op_wr_q;
    idx_d     = idx_q;
    accept_s  = 1'b0;
    rd_load_s = 1'b0;
    rd_beat_s = 2'd0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (pmem_read || pmem_write) begin
          accept_s = 1'b1;
          state_d  = ST_WAIT;
          wait_d   = '0;
          op_wr_d  = ~pmem_read;
          idx_d    = pmem_address[5 +: IW];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d   = ST_BURST;
          beat_d    = 2'd0;
          rd_load_s = ~op_wr_q;
          rd_beat_s = 2'd0;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      ST_BURST: begin
        if (beat_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          beat_d    = beat_q + 2'd1;
          rd_load_s = ~op_wr_q;
          rd_beat_s = beat_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdata_d = rd_load_s ? line_s[{rd_beat_s, 6'd0} +: 64] : 64'd0;
    resp_d  = (state_d == ST_BURST);
    busy_d  = (state_d != ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      beat_q  <= 2'd0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      rdata_q <= 64'd0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
    end
  end

  // Line storage is deliberately not reset; a reset mid-write keeps beats already committed.
  always_ff @(posedge clk) begin
    if ((state_q == ST_BURST) && op_wr_q) begin
      mem_q[idx_q][{beat_q, 6'd0} +: 64] <= pmem_wdata;
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;
  assign busy       = busy_q;

`ifdef PMEM_PROTO_CHECK_EN
  logic [26:0] addr_hi_q, addr_hi_d;
  logic        perr_q, perr_d;
  logic        viol_s;

  // Flags conflicting ops at acceptance and any change of the held request while in flight.
  always_comb begin
    addr_hi_d = accept_s ? pmem_address[31:5] : addr_hi_q;
    if (accept_s) begin
      viol_s = pmem_read && pmem_write;
    end else if ((state_q == ST_WAIT) || (state_q == ST_BURST)) begin
      viol_s = (op_wr_q ? ~pmem_write : ~pmem_read) || (pmem_address[31:5] != addr_hi_q);
    end else begin
      viol_s = 1'b0;
    end
    perr_d = perr_q | viol_s;
  end

  // Sticky error flag and latched request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hi_q <= 27'd0;
      perr_q    <= 1'b0;
    end else begin
      addr_hi_q <= addr_hi_d;
      perr_q    <= perr_d;
    end
  end

  assign protocol_err = perr_q;

  logic unused_s;
  assign unused_s = ^pmem_address[4:0];
`else
  logic unused_s;
  assign unused_s = ^{pmem_address[4:0], pmem_address[31:5+IW]};
`endif

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed plus randomized bench for pmem_burst_responder; two instances cover LATENCY=4 and LATENCY=1.
module tb_pmem_burst_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata [2];
  logic        resp  [2];
  logic        busy  [2];
`ifdef PMEM_PROTO_CHECK_EN
  logic        perr  [2];
`endif

  int ncmp  = 0;
  int nfail = 0;

  logic [255:0] model [int];
  logic [31:0]  wq0 [$];
  logic [31:0]  wq1 [$];

  always #5 clk = ~clk;

  pmem_burst_responder #(.DEPTH(DEPTH), .LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_rdata(rdata[0]),
    .pmem_resp(resp[0]), .busy(busy[0])
`ifdef PMEM_PROTO_CHECK_EN
    , .protocol_err(perr[0])
`endif
  );

  pmem_burst_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_rdata(rdata[1]),
    .pmem_resp(resp[1]), .busy(busy[1])
`ifdef PMEM_PROTO_CHECK_EN
    , .protocol_err(perr[1])
`endif
  );

  function automatic int lat(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Each instance has its own memory; line = (byte address / 32) mod DEPTH.
  function automatic int key(input int d, input logic [31:0] a);
    return d * DEPTH + int'((a >> 5) % DEPTH);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. Drives one request and checks every cycle up to and after DONE.
  task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [255:0] wl, input int abort_beat, input bit keep);
    int L;
    int k;
    int kk;
    logic [255:0] exp_line;
    logic [255:0] tmp;
    L  = lat(d);
    kk = key(d, a);
    exp_line = (r && model.exists(kk)) ? model[kk] : 256'd0;
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = 64'd0;
    @(posedge clk);
    for (int c = 0; c <= L + 4; c++) begin
      @(negedge clk);
      k = c - L;
      if (k == abort_beat) begin
        rst = 1'b1;
        #1;
        check("rst_resp", {63'd0, resp[d]}, 64'd0);
        check("rst_busy", {63'd0, busy[d]}, 64'd0);
        check("rst_rdata", rdata[d], 64'd0);
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tmp = model[kk];
        for (int b = 0; b < abort_beat; b++) tmp[64*b +: 64] = wl[64*b +: 64];
        model[kk] = tmp;
        return;
      end
      check("resp", {63'd0, resp[d]}, {63'd0, (k >= 0 && k < 4)});
      check("busy", {63'd0, busy[d]}, 64'd1);
      if (k >= 0 && k < 4) begin
        if (r) check("rdata", rdata[d], exp_line[64*k +: 64]);
        else   wdata[d] = wl[64*k +: 64];
      end
      if (c == L + 4 && !keep) begin
        rd[d] = 1'b0; wr[d] = 1'b0;
      end
    end
    if (w && !r) model[kk] = wl;
    if (!keep) begin
      @(negedge clk);
      check("idle_busy", {63'd0, busy[d]}, 64'd0);
      check("idle_resp", {63'd0, resp[d]}, 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [31:0]  a;
    int d;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 64'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_resp", {63'd0, resp[i]}, 64'd0);
      check("reset_busy", {63'd0, busy[i]}, 64'd0);
      check("reset_rdata", rdata[i], 64'd0);
`ifdef PMEM_PROTO_CHECK_EN
      check("reset_perr", {63'd0, perr[i]}, 64'd0);
`endif
    end
    rst = 1'b0;
    @(negedge clk);

    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    txn(0, 1'b0, 1'b1, 32'h0000_0040, line_a, 99, 1'b0);
    txn(0, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 99, 1'b0);

    line_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    txn(1, 1'b0, 1'b1, 32'h0000_0040, line_b, 99, 1'b0);
    txn(1, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 99, 1'b0);

    line_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    txn(0, 1'b0, 1'b1, 32'h0000_2040, line_b, 99, 1'b0);
    txn(0, 1'b1, 1'b0, 32'h0000_005F, 256'd0, 99, 1'b0);

    txn(0, 1'b0, 1'b1, 32'h0000_0080, line_a, 99, 1'b0);
    txn(0, 1'b1, 1'b1, 32'h0000_0080, ~line_a, 99, 1'b0);
`ifdef PMEM_PROTO_CHECK_EN
    check("perr_set", {63'd0, perr[0]}, 64'd1);
`endif
    txn(0, 1'b1, 1'b0, 32'h0000_0080, 256'd0, 99, 1'b0);
`ifdef PMEM_PROTO_CHECK_EN
    check("perr_sticky", {63'd0, perr[0]}, 64'd1);
`endif

    line_b = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    txn(0, 1'b0, 1'b1, 32'h0000_00C0, line_b, 99, 1'b0);
    line_b = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
              64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    txn(0, 1'b0, 1'b1, 32'h0000_00C0, line_b, 2, 1'b0);
`ifdef PMEM_PROTO_CHECK_EN
    check("perr_cleared", {63'd0, perr[0]}, 64'd0);
`endif
    txn(0, 1'b1, 1'b0, 32'h0000_00C0, 256'd0, 99, 1'b0);

    for (int i = 0; i < 2; i++) begin
      txn(i, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 99, 1'b1);
      txn(i, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 99, 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      d = int'($urandom_range(0, 1));
      if ((d == 0 && wq0.size() == 0) || (d == 1 && wq1.size() == 0) || $urandom_range(0, 1) == 0) begin
        a = $urandom;
        line_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        txn(d, 1'b0, 1'b1, a, line_b, 99, 1'b0);
        if (d == 0) wq0.push_back(a); else wq1.push_back(a);
      end else begin
        if (d == 0) a = wq0[$urandom_range(0, wq0.size() - 1)];
        else        a = wq1[$urandom_range(0, wq1.size() - 1)];
        a = (a & 32'h0000_1FE0) | ($urandom & 32'hFFFF_E01F);
        txn(d, 1'b1, 1'b0, a, 256'd0, 99, 1'b0);
      end
    end

`ifdef PMEM_PROTO_CHECK_EN
    check("perr_clean_run", {63'd0, perr[1]}, 64'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
